// File: rtl/dm_hs_mem.sv
// dm_hs_mem: data memory with valid/ready handshake, programmable wait states,
// big-endian lane steering for stores and extend/byte-reverse extraction for loads.
module dm_hs_mem #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE        = '0,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic              req_rev,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q, sgn_q, rev_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              c_we, c_sgn, c_rev, err, fire;
    logic [ADDR_W-1:0] c_addr, off;
    logic [1:0]        c_size;
    logic [DATA_W-1:0] c_wdata, word, wword, field, ext, rd_nxt;
    logic [AW-1:0]     widx;
    int                ln, n;

    // With zero wait states the access resolves on the accept edge, so decode
    // straight from the request port while idle and from the latches otherwise.
    always_comb begin
        c_we    = state == IDLE ? req_we : we_q;
        c_addr  = state == IDLE ? req_addr : addr_q;
        c_size  = state == IDLE ? req_size : size_q;
        c_sgn   = state == IDLE ? req_signed : sgn_q;
        c_rev   = state == IDLE ? req_rev : rev_q;
        c_wdata = state == IDLE ? req_wdata : wdata_q;
        off     = c_addr - BASE;
        ln      = int'(off[LB-1:0]);
        n       = 1 << c_size;
        widx    = off[LB +: AW];
        err     = (|(off >> (LB + AW))) || ((8 << c_size) > DATA_W) || (ln % n != 0);
        word    = mem[widx];
        wword   = word;
        field   = '0;
        for (int k = 0; k < NB; k++)
            if (k < n && ln + k < NB) begin
                wword[DATA_W-1-8*(ln+k) -: 8] = c_wdata[8*(c_rev ? k : n-1-k) +: 8];
                field[8*(c_rev ? k : n-1-k) +: 8] = word[DATA_W-1-8*(ln+k) -: 8];
            end
        ext     = (c_sgn && 8 * n < DATA_W && field[8*n-1]) ? field | ({DATA_W{1'b1}} << 8 * n) : field;
        rd_nxt  = (err || c_we) ? '0 : ext;
    end

    assign fire = rst_n && (state == WAIT ? cnt == 4'd0 : state == IDLE && req_valid && WAIT_CYCLES == 0);

    // Memory is not reset; a store lands only on the edge that enters RESP.
    always_ff @(posedge clk)
        if (fire && c_we && !err)
            mem[widx] <= wword;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            sgn_q     <= 1'b0;
            rev_q     <= 1'b0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q      <= req_we;
                    addr_q    <= req_addr;
                    size_q    <= req_size;
                    sgn_q     <= req_signed;
                    rev_q     <= req_rev;
                    wdata_q   <= req_wdata;
                    req_ready <= 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rd_nxt;
                        rsp_err   <= err;
                    end else begin
                        state <= WAIT;
                        cnt   <= 4'(WAIT_CYCLES - 1);
                    end
                end
                WAIT: if (cnt == 4'd0) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rd_nxt;
                    rsp_err   <= err;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_hs_mem.sv
// tb_dm_hs_mem: scoreboard bench for a 32-bit/2-wait instance and a 64-bit/0-wait instance.
module tb_dm_hs_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0, n_bad = 0;

    typedef struct {
        string       name;
        logic [63:0] d;
        logic        e;
    } exp_t;

    exp_t qa[$], qb[$];
    exp_t xa, xb;

    logic        a_rst_n = 1'b0, a_req_valid = 1'b0, a_we = 1'b0, a_sgn = 1'b0, a_rev = 1'b0, a_rsp_ready = 1'b1;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic [1:0]  a_size = '0;
    logic        a_req_ready, a_rsp_valid, a_err;
    logic [31:0] a_rdata;

    logic        b_rst_n = 1'b0, b_req_valid = 1'b0, b_we = 1'b0, b_sgn = 1'b0, b_rev = 1'b0, b_rsp_ready = 1'b1;
    logic [31:0] b_addr = '0;
    logic [63:0] b_wdata = '0;
    logic [1:0]  b_size = '0;
    logic        b_req_ready, b_rsp_valid, b_err;
    logic [63:0] b_rdata;

    dm_hs_mem #(.DATA_W(32), .WAIT_CYCLES(2)) ua (
        .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_we), .req_addr(a_addr), .req_size(a_size), .req_signed(a_sgn),
        .req_rev(a_rev), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid),
        .rsp_ready(a_rsp_ready), .rsp_rdata(a_rdata), .rsp_err(a_err)
    );

    dm_hs_mem #(.DATA_W(64), .WAIT_CYCLES(0)) ub (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_we), .req_addr(b_addr), .req_size(b_size), .req_signed(b_sgn),
        .req_rev(b_rev), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid),
        .rsp_ready(b_rsp_ready), .rsp_rdata(b_rdata), .rsp_err(b_err)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitors sample on the falling edge; the accept-to-visible-valid distance is WAIT_CYCLES+1.
    int a_tacc, a_trsp, b_tacc, b_trsp;
    bit a_busy, a_seen, a_rdybad, b_busy, b_seen, b_rdybad;

    always @(negedge clk) begin
        if (!a_rst_n) begin
            a_busy = 0;
            a_seen = 0;
        end else begin
            if (a_busy && a_req_ready) a_rdybad = 1;
            if (a_busy && a_rsp_valid && !a_seen) begin a_seen = 1; a_trsp = cyc; end
            if (a_rsp_valid && a_rsp_ready) begin
                if (qa.size() == 0) chk("a_unexpected_rsp", 64'd1, 64'd0);
                else begin
                    xa = qa.pop_front();
                    chk({xa.name, "_data"}, 64'(a_rdata), xa.d);
                    chk({xa.name, "_err"}, 64'(a_err), 64'(xa.e));
                    chk({xa.name, "_lat"}, 64'(a_trsp - a_tacc), 64'd3);
                    chk({xa.name, "_rdy_low"}, 64'(a_rdybad), 64'd0);
                end
                a_busy = 0;
                a_seen = 0;
            end
            if (a_req_valid && a_req_ready) begin a_busy = 1; a_seen = 0; a_rdybad = 0; a_tacc = cyc; end
        end
    end

    always @(negedge clk) begin
        if (!b_rst_n) begin
            b_busy = 0;
            b_seen = 0;
        end else begin
            if (b_busy && b_req_ready) b_rdybad = 1;
            if (b_busy && b_rsp_valid && !b_seen) begin b_seen = 1; b_trsp = cyc; end
            if (b_rsp_valid && b_rsp_ready) begin
                if (qb.size() == 0) chk("b_unexpected_rsp", 64'd1, 64'd0);
                else begin
                    xb = qb.pop_front();
                    chk({xb.name, "_data"}, b_rdata, xb.d);
                    chk({xb.name, "_err"}, 64'(b_err), 64'(xb.e));
                    chk({xb.name, "_lat"}, 64'(b_trsp - b_tacc), 64'd1);
                    chk({xb.name, "_rdy_low"}, 64'(b_rdybad), 64'd0);
                end
                b_busy = 0;
                b_seen = 0;
            end
            if (b_req_valid && b_req_ready) begin b_busy = 1; b_seen = 0; b_rdybad = 0; b_tacc = cyc; end
        end
    end

    task automatic issue_a(string name, logic we, logic [31:0] addr, logic [1:0] size, logic sgn, logic rev,
                           logic [31:0] wd, logic [31:0] d, logic e, bit push);
        exp_t x;
        x.name = name; x.d = 64'(d); x.e = e;
        if (push) qa.push_back(x);
        a_we = we; a_addr = addr; a_size = size; a_sgn = sgn; a_rev = rev; a_wdata = wd; a_req_valid = 1'b1;
        for (int i = 0; i < 50 && !a_req_ready; i++) tick(1);
        if (!a_req_ready) chk({name, "_accept_timeout"}, 64'd0, 64'd1);
        tick(1);
        a_req_valid = 1'b0;
    endtask

    task automatic issue_b(string name, logic we, logic [31:0] addr, logic [1:0] size, logic sgn, logic rev,
                           logic [63:0] wd, logic [63:0] d, logic e);
        exp_t x;
        x.name = name; x.d = d; x.e = e;
        qb.push_back(x);
        b_we = we; b_addr = addr; b_size = size; b_sgn = sgn; b_rev = rev; b_wdata = wd; b_req_valid = 1'b1;
        for (int i = 0; i < 50 && !b_req_ready; i++) tick(1);
        if (!b_req_ready) chk({name, "_accept_timeout"}, 64'd0, 64'd1);
        tick(1);
        b_req_valid = 1'b0;
    endtask

    task automatic drain_a();
        for (int i = 0; i < 40 && qa.size() != 0; i++) tick(1);
        chk("drain_a", 64'(qa.size()), 64'd0);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 40 && qb.size() != 0; i++) tick(1);
        chk("drain_b", 64'(qb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        chk("a_rst_ready", 64'(a_req_ready), 64'd1);
        chk("a_rst_valid", 64'(a_rsp_valid), 64'd0);
        chk("a_rst_rdata", 64'(a_rdata), 64'd0);
        chk("a_rst_err", 64'(a_err), 64'd0);
        chk("b_rst_ready", 64'(b_req_ready), 64'd1);
        chk("b_rst_valid", 64'(b_rsp_valid), 64'd0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick(1);

        // name            we  addr      sz sgn rev wdata          expect         err push
        issue_a("st_w10",  1, 32'h10,   2, 0, 0, 32'h11223344, 32'h0,        0, 1);
        issue_a("ld_w10",  0, 32'h10,   2, 0, 0, 32'h0,        32'h11223344, 0, 1);
        issue_a("st_b13",  1, 32'h13,   0, 0, 0, 32'h000000AA, 32'h0,        0, 1);
        issue_a("ld_w10b", 0, 32'h10,   2, 0, 0, 32'h0,        32'h112233AA, 0, 1);
        issue_a("ld_sb13", 0, 32'h13,   0, 1, 0, 32'h0,        32'hFFFFFFAA, 0, 1);
        issue_a("ld_ub13", 0, 32'h13,   0, 0, 0, 32'h0,        32'h000000AA, 0, 1);
        issue_a("ld_hr12", 0, 32'h12,   1, 0, 1, 32'h0,        32'h0000AA33, 0, 1);
        issue_a("ld_sh10", 0, 32'h10,   1, 1, 0, 32'h0,        32'h00001122, 0, 1);
        issue_a("st_wr20", 1, 32'h20,   2, 0, 1, 32'h01020304, 32'h0,        0, 1);
        issue_a("ld_w20",  0, 32'h20,   2, 0, 0, 32'h0,        32'h04030201, 0, 1);
        issue_a("st_h22",  1, 32'h22,   1, 0, 0, 32'h00008001, 32'h0,        0, 1);
        issue_a("ld_sh22", 0, 32'h22,   1, 1, 0, 32'h0,        32'hFFFF8001, 0, 1);
        issue_a("ld_w20b", 0, 32'h20,   2, 0, 0, 32'h0,        32'h04038001, 0, 1);
        issue_a("ld_mis",  0, 32'h11,   2, 0, 0, 32'h0,        32'h0,        1, 1);
        issue_a("ld_mish", 0, 32'h11,   1, 0, 0, 32'h0,        32'h0,        1, 1);
        issue_a("st_w0",   1, 32'h0,    2, 0, 0, 32'h55667788, 32'h0,        0, 1);
        issue_a("st_oor",  1, 32'h1000, 2, 0, 0, 32'hCAFEBABE, 32'h0,        1, 1);
        issue_a("ld_w0",   0, 32'h0,    2, 0, 0, 32'h0,        32'h55667788, 0, 1);
        issue_a("st_d18",  1, 32'h18,   3, 0, 0, 32'h12345678, 32'h0,        1, 1);
        issue_a("st_bfff", 1, 32'hFFF,  0, 0, 0, 32'h0000005A, 32'h0,        0, 1);
        issue_a("ld_bfff", 0, 32'hFFF,  0, 0, 0, 32'h0,        32'h0000005A, 0, 1);
        drain_a();

        // Response held while the consumer stalls.
        a_rsp_ready = 1'b0;
        issue_a("hold", 0, 32'h10, 2, 0, 0, 32'h0, 32'h112233AA, 0, 1);
        for (int i = 0; i < 20 && !a_rsp_valid; i++) tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 64'(a_rsp_valid), 64'd1);
            chk("hold_rdata", 64'(a_rdata), 64'h112233AA);
            chk("hold_err", 64'(a_err), 64'd0);
            chk("hold_ready", 64'(a_req_ready), 64'd0);
            tick(1);
        end
        a_rsp_ready = 1'b1;
        tick(1);
        chk("release_valid", 64'(a_rsp_valid), 64'd0);
        chk("release_ready", 64'(a_req_ready), 64'd1);
        drain_a();

        // Reset in the middle of a store's wait window.
        issue_a("st_w40", 1, 32'h40, 2, 0, 0, 32'h0BADF00D, 32'h0, 0, 1);
        drain_a();
        issue_a("st_dead", 1, 32'h40, 2, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0);
        a_rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(a_req_ready), 64'd1);
        chk("arst_valid", 64'(a_rsp_valid), 64'd0);
        chk("arst_rdata", 64'(a_rdata), 64'd0);
        chk("arst_err", 64'(a_err), 64'd0);
        tick(3);
        a_rst_n = 1'b1;
        tick(1);
        issue_a("ld_w40", 0, 32'h40, 2, 0, 0, 32'h0, 32'h0BADF00D, 0, 1);
        drain_a();

        // 64-bit instance, zero wait states.
        issue_b("b_st_d8",  1, 32'h8, 3, 0, 0, 64'h0123456789ABCDEF, 64'h0,                0);
        issue_b("b_ld_d8",  0, 32'h8, 3, 0, 0, 64'h0,                64'h0123456789ABCDEF, 0);
        issue_b("b_ld_sd8", 0, 32'h8, 3, 1, 0, 64'h0,                64'h0123456789ABCDEF, 0);
        issue_b("b_ld_wC",  0, 32'hC, 2, 0, 0, 64'h0,                64'h0000000089ABCDEF, 0);
        issue_b("b_ld_sbC", 0, 32'hC, 0, 1, 0, 64'h0,                64'hFFFFFFFFFFFFFF89, 0);
        issue_b("b_ld_sw8", 0, 32'h8, 2, 1, 0, 64'h0,                64'h0000000001234567, 0);
        issue_b("b_ld_dr8", 0, 32'h8, 3, 0, 1, 64'h0,                64'hEFCDAB8967452301, 0);
        issue_b("b_ld_mis", 0, 32'hA, 2, 0, 0, 64'h0,                64'h0,                1);
        drain_b();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
